// File: rtl/cic_pkg.sv
// Shared definitions for the CIC decimator: accumulator sizing,
// output-side FSM states and decimation-rate legalisation.
package cic_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } cic_state_t;

  function automatic int cic_acc_width(input int in_w, input int n_stages, input int rlog2_max);
    return in_w + n_stages * rlog2_max;
  endfunction

  // Out-of-range rates fall back to the largest supported rate.
  function automatic int cic_legal_rate(input int rate, input int rlog2_max);
    return (rate < 1 || rate > rlog2_max) ? rlog2_max : rate;
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One comb section running at the decimated rate: y = x - x(previous event).
module cic_comb_stage #(
  parameter int W = 28
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         flush,
  input  logic         en,
  input  logic [W-1:0] c_in,
  output logic [W-1:0] c_out
);

  logic [W-1:0] delay_reg;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      delay_reg <= '0;
    end else if (flush) begin
      delay_reg <= '0;
    end else if (en) begin
      delay_reg <= c_in;
    end
  end

  assign c_out = c_in - delay_reg;

endmodule

// File: rtl/cic_decimator.sv
// N-stage CIC decimator with power-of-two rate, gain normalisation by
// arithmetic shift and AXI-Stream style handshaking on both sides.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int N_STAGES  = 3,
  parameter int RLOG2_MAX = 4
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [$clog2(RLOG2_MAX+1)-1:0] rate_log2,
  input  logic                           clear,
  input  logic [IN_W-1:0]                s_axis_data_tdata,
  input  logic                           s_axis_data_tvalid,
  output logic                           s_axis_data_tready,
  output logic [IN_W-1:0]                m_axis_data_tdata,
  output logic                           m_axis_data_tvalid,
  input  logic                           m_axis_data_tready
);

  localparam int ACC_W = cic_acc_width(IN_W, N_STAGES, RLOG2_MAX);
  localparam int RW    = $clog2(RLOG2_MAX + 1);
  localparam int PW    = RLOG2_MAX;
  localparam int SW    = $clog2(N_STAGES * RLOG2_MAX + 1);

  logic [RW-1:0]    rate_reg;
  logic [RW-1:0]    rate_legal;
  logic [PW-1:0]    phase_reg;
  logic [PW-1:0]    last_phase;
  logic [SW-1:0]    shamt;
  logic [IN_W-1:0]  out_data_reg;
  logic [IN_W-1:0]  out_next;
  logic             out_valid_reg;
  logic             flush;
  logic             accept;
  logic             dec;
  logic [ACC_W-1:0] x_ext;
  logic [ACC_W-1:0] integ_next [N_STAGES];
  logic [ACC_W-1:0] comb_sig   [N_STAGES+1];
  cic_state_t       state_reg;
  cic_state_t       state_next;

  assign rate_legal = RW'(cic_legal_rate(int'(rate_log2), RLOG2_MAX));
  assign flush      = clear || (rate_legal != rate_reg);
  assign s_axis_data_tready = !(out_valid_reg && !m_axis_data_tready);
  assign accept     = s_axis_data_tvalid && s_axis_data_tready;
  assign last_phase = PW'((1 << rate_reg) - 1);
  assign dec        = accept && !flush && (phase_reg == last_phase);
  assign x_ext      = {{(ACC_W-IN_W){s_axis_data_tdata[IN_W-1]}}, s_axis_data_tdata};

  // Integrator chain: every stage sees the already-updated value of the
  // previous stage, so the whole cascade advances in a single edge.
  for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_integ
    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] addend;
    if (gi == 0) begin : g_first
      assign addend = x_ext;
    end else begin : g_rest
      assign addend = integ_next[gi-1];
    end
    assign integ_next[gi] = acc_reg + addend;

    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        acc_reg <= '0;
      end else if (flush) begin
        acc_reg <= '0;
      end else if (accept) begin
        acc_reg <= integ_next[gi];
      end
    end
  end

  assign comb_sig[0] = integ_next[N_STAGES-1];

  for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_comb
    cic_comb_stage #(.W(ACC_W)) u_comb (
      .aclk    (aclk),
      .aresetn (aresetn),
      .flush   (flush),
      .en      (dec),
      .c_in    (comb_sig[gi]),
      .c_out   (comb_sig[gi+1])
    );
  end

  // Gain is R^N = 2^(N*rate_log2); floor division keeps the DC level exact.
  assign shamt    = SW'(N_STAGES * int'(rate_reg));
  assign out_next = IN_W'($signed(comb_sig[N_STAGES]) >>> shamt);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rate_reg      <= RW'(RLOG2_MAX);
      phase_reg     <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      state_reg     <= ST_RUN;
    end else begin
      rate_reg  <= rate_legal;
      state_reg <= state_next;
      if (flush) begin
        phase_reg     <= '0;
        out_valid_reg <= 1'b0;
      end else begin
        if (accept) begin
          phase_reg <= (phase_reg == last_phase) ? '0 : phase_reg + 1'b1;
        end
        if (dec) begin
          out_data_reg  <= out_next;
          out_valid_reg <= 1'b1;
        end else if (out_valid_reg && m_axis_data_tready) begin
          out_valid_reg <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:  if (out_valid_reg && !m_axis_data_tready) state_next = ST_HOLD;
      ST_HOLD: if (out_valid_reg && m_axis_data_tready)  state_next = ST_RUN;
      default: state_next = ST_RUN;
    endcase
    if (flush) state_next = ST_RUN;
  end

  assign m_axis_data_tdata  = out_data_reg;
  assign m_axis_data_tvalid = out_valid_reg;

endmodule
